// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter serialising load/store transactions onto the single data-side
// bridge port, with a fixed read latency and a one-cycle ack back to the winner.
module mips_bus_arbiter #(
    parameter int RD_LAT = 1,
    parameter int RR_EN  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_byteen,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_byteen,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rdata,
    output logic        o_bus_valid,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_byteen,
    input  logic [31:0] i_bus_rdata,
    output logic        o_owner,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] CNT_INIT = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byteen;
    logic [31:0] r_rdata;
    logic [2:0]  r_cnt;
    logic        r_owner;
    logic        r_rr_m1;
    logic        w_any_req;
    logic        w_grant_m1;

    assign w_any_req = i_m0_req | i_m1_req;
    // M1 wins when alone, or on a tie when round-robin says it is M1's turn.
    assign w_grant_m1 = i_m1_req & (~i_m0_req | ((RR_EN != 0) & r_rr_m1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_any_req) w_next = ISSUE;
            ISSUE: w_next = ((r_byteen != 4'd0) || (RD_LAT == 0)) ? DONE : WAIT;
            WAIT:  if (r_cnt == 3'd0) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_byteen <= 4'd0;
            r_rdata  <= 32'd0;
            r_cnt    <= 3'd0;
            r_owner  <= 1'b0;
            r_rr_m1  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_grant_m1;
                        r_addr   <= w_grant_m1 ? i_m1_addr   : i_m0_addr;
                        r_wdata  <= w_grant_m1 ? i_m1_wdata  : i_m0_wdata;
                        r_byteen <= w_grant_m1 ? i_m1_byteen : i_m0_byteen;
                    end
                end
                ISSUE: begin
                    if (r_byteen != 4'd0) begin
                        r_rdata <= 32'd0;
                    end else if (RD_LAT == 0) begin
                        r_rdata <= i_bus_rdata;
                    end else begin
                        r_cnt <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_rdata <= i_bus_rdata;
                    end
                end
                DONE: r_rr_m1 <= ~r_owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_bus_valid  = (r_state == ISSUE);
        o_bus_byteen = (r_state == ISSUE) ? r_byteen : 4'd0;
        o_bus_addr   = r_addr;
        o_bus_wdata  = r_wdata;
        o_owner      = r_owner;
        o_busy       = (r_state != IDLE);
        o_m0_ack     = (r_state == DONE) & ~r_owner;
        o_m1_ack     = (r_state == DONE) & r_owner;
        o_m0_rdata   = o_m0_ack ? r_rdata : 32'd0;
        o_m1_rdata   = o_m1_ack ? r_rdata : 32'd0;
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: three instances (RD_LAT=2/RR, RD_LAT=0/fixed,
// RD_LAT=3/RR) share the stimulus; each scenario checks the instance it targets.
module tb_mips_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_byteen = '0, m1_byteen = '0;
    logic [31:0] bus_rdata = '0;

    logic        a_m0_ack, a_m1_ack, a_valid, a_owner, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata;
    logic [3:0]  a_byteen;
    logic        b_m0_ack, b_m1_ack, b_valid, b_owner, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata;
    logic [3:0]  b_byteen;
    logic        c_m0_ack, c_m1_ack, c_valid, c_owner, c_busy;
    logic [31:0] c_m0_rdata, c_m1_rdata, c_addr, c_wdata;
    logic [3:0]  c_byteen;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.RD_LAT(2), .RR_EN(1)) u_a (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_byteen(m0_byteen),
        .o_m0_ack(a_m0_ack), .o_m0_rdata(a_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_byteen(m1_byteen),
        .o_m1_ack(a_m1_ack), .o_m1_rdata(a_m1_rdata),
        .o_bus_valid(a_valid), .o_bus_addr(a_addr), .o_bus_wdata(a_wdata), .o_bus_byteen(a_byteen),
        .i_bus_rdata(bus_rdata), .o_owner(a_owner), .o_busy(a_busy));

    mips_bus_arbiter #(.RD_LAT(0), .RR_EN(0)) u_b (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_byteen(m0_byteen),
        .o_m0_ack(b_m0_ack), .o_m0_rdata(b_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_byteen(m1_byteen),
        .o_m1_ack(b_m1_ack), .o_m1_rdata(b_m1_rdata),
        .o_bus_valid(b_valid), .o_bus_addr(b_addr), .o_bus_wdata(b_wdata), .o_bus_byteen(b_byteen),
        .i_bus_rdata(bus_rdata), .o_owner(b_owner), .o_busy(b_busy));

    mips_bus_arbiter #(.RD_LAT(3), .RR_EN(1)) u_c (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_byteen(m0_byteen),
        .o_m0_ack(c_m0_ack), .o_m0_rdata(c_m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_byteen(m1_byteen),
        .o_m1_ack(c_m1_ack), .o_m1_rdata(c_m1_rdata),
        .o_bus_valid(c_valid), .o_bus_addr(c_addr), .o_bus_wdata(c_wdata), .o_bus_byteen(c_byteen),
        .i_bus_rdata(bus_rdata), .o_owner(c_owner), .o_busy(c_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [137:0] outs;
        m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111; m0_byteen = 4'hF;
        m1_req = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = 32'h2222_2222; m1_byteen = 4'hF;
        reset_n = 1'b0;
        tick();
        tick();
        outs = {a_m0_ack, a_m0_rdata, a_m1_ack, a_m1_rdata, a_valid, a_addr, a_wdata[3:0],
                a_byteen, a_owner, a_busy, a_wdata[31:4]};
        n_total++;
        if (outs !== '0) $display("FAIL reset_outputs_a got=%h want=0", outs);
        else n_pass++;
        n_total++;
        if ({b_m0_ack, b_m1_ack, b_valid, b_addr, b_byteen, b_owner, b_busy, b_m0_rdata} !== '0)
            $display("FAIL reset_outputs_b got nonzero outputs want=0");
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_total++;
        if ({a_valid, a_owner, a_addr} !== {1'b1, 1'b0, 32'h0000_0100})
            $display("FAIL reset_first_grant got valid=%b owner=%b addr=%h want 1 0 00000100",
                     a_valid, a_owner, a_addr);
        else n_pass++;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_m0_store();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_wdata = 32'h0000_1234; m0_byteen = 4'hF;
        n_total++;
        if (a_byteen !== 4'h0) $display("FAIL store_byteen_idle got=%h want=0", a_byteen);
        else n_pass++;
        tick();
        n_total++;
        if ({a_valid, a_addr, a_wdata, a_byteen, a_busy} !== {1'b1, 32'h0000_7F00, 32'h0000_1234, 4'hF, 1'b1})
            $display("FAIL store_issue got valid=%b addr=%h wdata=%h be=%h busy=%b want 1 00007f00 00001234 f 1",
                     a_valid, a_addr, a_wdata, a_byteen, a_busy);
        else n_pass++;
        tick();
        n_total++;
        if ({a_m0_ack, a_m0_rdata, a_m1_ack, a_valid, a_byteen} !== {1'b1, 32'h0, 1'b0, 1'b0, 4'h0})
            $display("FAIL store_ack got ack0=%b rdata0=%h ack1=%b valid=%b be=%h want 1 0 0 0 0",
                     a_m0_ack, a_m0_rdata, a_m1_ack, a_valid, a_byteen);
        else n_pass++;
        m0_req = 1'b0;
        tick();
        n_total++;
        if ({a_m0_ack, a_busy, a_byteen, a_addr} !== {1'b0, 1'b0, 4'h0, 32'h0000_7F00})
            $display("FAIL store_after got ack=%b busy=%b be=%h addr=%h want 0 0 0 00007f00",
                     a_m0_ack, a_busy, a_byteen, a_addr);
        else n_pass++;
    endtask

    task automatic test_m1_load_lat2();
        do_reset();
        bus_rdata = 32'h1111_1111;
        m1_req = 1'b1; m1_addr = 32'h0000_7F10; m1_wdata = 32'h0; m1_byteen = 4'h0;
        tick();
        n_total++;
        if ({a_valid, a_owner, a_addr, a_byteen} !== {1'b1, 1'b1, 32'h0000_7F10, 4'h0})
            $display("FAIL load_issue got valid=%b owner=%b addr=%h be=%h want 1 1 00007f10 0",
                     a_valid, a_owner, a_addr, a_byteen);
        else n_pass++;
        tick();
        n_total++;
        if ({a_valid, a_busy, a_m0_ack, a_m1_ack} !== 4'b0100)
            $display("FAIL load_wait1 got valid=%b busy=%b ack0=%b ack1=%b want 0 1 0 0",
                     a_valid, a_busy, a_m0_ack, a_m1_ack);
        else n_pass++;
        tick();
        bus_rdata = 32'hDEAD_BEEF;
        n_total++;
        if ({a_valid, a_busy, a_m1_ack} !== 3'b010)
            $display("FAIL load_wait2 got valid=%b busy=%b ack1=%b want 0 1 0", a_valid, a_busy, a_m1_ack);
        else n_pass++;
        tick();
        bus_rdata = 32'h2222_2222;
        n_total++;
        if ({a_m1_ack, a_m1_rdata, a_m0_ack, a_m0_rdata} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0})
            $display("FAIL load_ack got ack1=%b rdata1=%h ack0=%b rdata0=%h want 1 deadbeef 0 0",
                     a_m1_ack, a_m1_rdata, a_m0_ack, a_m0_rdata);
        else n_pass++;
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic [3:0] a_order;
        int a_cnt = 0;
        int b_m0_cnt = 0;
        int b_m1_cnt = 0;
        a_order = '0;
        do_reset();
        m0_req = 1'b1; m0_byteen = 4'h0; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_byteen = 4'h0; m1_addr = 32'h0000_0020;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_m0_ack | a_m1_ack) begin
                if (a_cnt < 4) a_order[a_cnt] = a_m1_ack;
                a_cnt++;
            end
            if (b_m0_ack) b_m0_cnt++;
            if (b_m1_ack) b_m1_cnt++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        n_total++;
        if (a_cnt !== 4) $display("FAIL rr_ack_count got=%0d want=4", a_cnt);
        else n_pass++;
        n_total++;
        if (a_order !== 4'b1010) $display("FAIL rr_order got=%b want=1010 (bit0 first, 1=M1)", a_order);
        else n_pass++;
        n_total++;
        if (b_m0_cnt !== 7) $display("FAIL fixed_m0_count got=%0d want=7", b_m0_cnt);
        else n_pass++;
        n_total++;
        if (b_m1_cnt !== 0) $display("FAIL fixed_m1_count got=%0d want=0", b_m1_cnt);
        else n_pass++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_in_wait();
        int spurious = 0;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0040; m0_byteen = 4'h0;
        m1_req = 1'b0;
        tick();
        tick();
        tick();
        n_total++;
        if ({c_busy, c_valid, c_owner} !== 3'b100)
            $display("FAIL abort_in_wait got busy=%b valid=%b owner=%b want 1 0 0", c_busy, c_valid, c_owner);
        else n_pass++;
        reset_n = 1'b0;
        m0_req = 1'b0;
        tick();
        reset_n = 1'b1;
        n_total++;
        if ({c_busy, c_m0_ack, c_m1_ack} !== 3'b000)
            $display("FAIL abort_idle got busy=%b ack0=%b ack1=%b want 0 0 0", c_busy, c_m0_ack, c_m1_ack);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (c_m0_ack | c_m1_ack | c_busy) spurious++;
        end
        n_total++;
        if (spurious !== 0) $display("FAIL abort_no_ack got=%0d cycles with activity want=0", spurious);
        else n_pass++;
        m0_req = 1'b1; m1_req = 1'b1; m1_byteen = 4'hF;
        tick();
        n_total++;
        if ({c_valid, c_owner} !== 2'b10)
            $display("FAIL abort_next_grant got valid=%b owner=%b want 1 0", c_valid, c_owner);
        else n_pass++;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_lat0_load();
        do_reset();
        bus_rdata = 32'h3333_3333;
        m0_req = 1'b1; m0_addr = 32'h0000_0080; m0_byteen = 4'h0;
        tick();
        bus_rdata = 32'h0000_00A5;
        n_total++;
        if ({b_valid, b_owner, b_addr} !== {1'b1, 1'b0, 32'h0000_0080})
            $display("FAIL lat0_issue got valid=%b owner=%b addr=%h want 1 0 00000080", b_valid, b_owner, b_addr);
        else n_pass++;
        tick();
        bus_rdata = 32'h4444_4444;
        n_total++;
        if ({b_m0_ack, b_m0_rdata, b_m1_ack} !== {1'b1, 32'h0000_00A5, 1'b0})
            $display("FAIL lat0_ack got ack0=%b rdata0=%h ack1=%b want 1 000000a5 0", b_m0_ack, b_m0_rdata, b_m1_ack);
        else n_pass++;
        m0_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_m0_store();
        test_m1_load_lat2();
        test_arbitration();
        test_reset_in_wait();
        test_lat0_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master arbiter that shares the single data-side bus port in front of mips_Bridge. Master 0 is the CPU M-stage data port. Master 1 is an auxiliary master (DMA or debug loader). The block serialises their load/store transactions, supports a fixed read latency, and returns read data plus a one-cycle ack to the winning master. The bus side connects directly to the bridge's address, write-data, byte-enable and read-data pins.

Parameters:
- RD_LAT, 1, cycles from the issue cycle to the cycle where i_bus_rdata is valid. Legal range 0..7; 0 means same-cycle (combinational) read.
- RR_EN, 1, 1 selects round-robin arbitration; 0 selects fixed priority with M0 highest.

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_m0_req  in  1  M0 request; addr/wdata/byteen must stay stable while req is high.
- i_m0_addr  in  32  M0 byte address.
- i_m0_wdata  in  32  M0 store data.
- i_m0_byteen  in  4  M0 byte enables; nonzero means store, 0 means load.
- o_m0_ack  out  1  one-cycle completion pulse to M0.
- o_m0_rdata  out  32  M0 load data; valid when o_m0_ack=1.
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_byteen  in  1/32/32/4  M1 equivalents.
- o_m1_ack, o_m1_rdata  out  1/32  M1 equivalents.
- o_bus_valid  out  1  high for exactly the issue cycle.
- o_bus_addr  out  32  latched address of the granted request.
- o_bus_wdata  out  32  latched store data of the granted request.
- o_bus_byteen  out  4  latched byteen, gated by o_bus_valid (0 outside ISSUE).
- i_bus_rdata  in  32  read data from the bridge.
- o_owner  out  1  current or last granted master.
- o_busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - state goes to IDLE; round-robin pointer is cleared to favour M0.
  - all outputs are 0; the internal addr/wdata/byteen/rdata registers are 0.
  - Reset asserted in any state aborts the transaction silently: no ack is issued and the next cycle is IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample i_m0_req and i_m1_req. If neither is high, stay in IDLE.
  - Otherwise pick a winner, latch its addr/wdata/byteen, set o_owner, and go to ISSUE.
  - Arbitration with both requests high: if RR_EN=1, grant the master that was not the last owner; if RR_EN=0, grant M0.
  - With only one request high, that master wins regardless of policy.
- ISSUE:
  - o_bus_valid=1 for exactly one cycle; o_bus_byteen equals the latched byteen.
  - Store (byteen != 0): go to DONE; the captured rdata is 0.
  - Load with RD_LAT=0: capture i_bus_rdata in this cycle and go to DONE.
  - Load with RD_LAT>=1: load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture i_bus_rdata (the cycle ISSUE+RD_LAT) and go to DONE.
  - o_bus_valid=0 and o_bus_byteen=0 throughout WAIT.
- DONE:
  - o_mX_ack=1 for the owner only; o_mX_rdata = captured data. The non-owner's ack and rdata are 0.
  - Update the round-robin pointer: last owner = o_owner.
  - Go to IDLE.
  - Requests are not sampled in DONE.
- Handshake: a request is consumed at the rising edge where its ack=1. The master must drive its next req value, registered, from that edge. A req still high in the following IDLE cycle is treated as a new transaction.
- A req dropped before it is granted is simply not served; no error is raised.
- Latency from the IDLE sample cycle to ack: stores 2 cycles; loads 2+RD_LAT cycles. At most one transaction is outstanding.
- Address, data and byteen pass through unmodified: no alignment check, no address decode. Decode stays in the bridge.
- o_bus_addr and o_bus_wdata hold their last latched values outside ISSUE. Only byteen and valid are gated.
- o_busy = (state != IDLE).

Test Plan:
1. Reset: hold i_reset_n=0 for 2 cycles with both reqs high -> all outputs 0; first grant after release goes to M0.
2. M0 store, addr 0x0000_7F00, wdata 0x0000_1234, byteen 4'hF, sampled in cycle T -> at T+1, o_bus_valid=1 with those values; at T+2, o_m0_ack=1 with o_m0_rdata=0; o_bus_byteen=0 in every other cycle.
3. RD_LAT=2, M1 load at 0x0000_7F10, bridge drives 0xDEADBEEF only at ISSUE+2 -> o_m1_ack=1 with rdata 0xDEADBEEF one cycle later; o_m0_ack stays 0.
4. Both reqs held high (re-asserted after each ack), RR_EN=1 -> grant order M0, M1, M0, M1. With RR_EN=0 -> M0 every time and M1 is never acked.
5. Reset pulsed during WAIT (RD_LAT=3) -> IDLE in the next cycle, no ack ever issued for the aborted load, and the next simultaneous request goes to M0.
6. RD_LAT=0, M0 load, bridge returns 0x0000_00A5 combinationally during ISSUE -> o_m0_ack at ISSUE+1 with rdata 0x0000_00A5.
